// File: rtl/cache_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
// cache_fill_ctrl_if : miss, memory-read and cache-fill bundle for cache_fill_ctrl
// Rev 1.0
// ============================================================================
interface cache_fill_ctrl_if #(
  parameter int BLOCK_WORDS = 8
) ();
  localparam int WW = $clog2(BLOCK_WORDS);

  logic          i_miss;
  logic [15:0]   i_miss_addr;
  logic          d_miss;
  logic [15:0]   d_miss_addr;
  logic          mem_en;
  logic [15:0]   mem_addr;
  logic          mem_data_valid;
  logic [15:0]   mem_data;
  logic          fill_we_i;
  logic          fill_we_d;
  logic [WW-1:0] fill_word;
  logic [15:0]   fill_data;
  logic [15:0]   fill_block_addr;
  logic          tag_we_i;
  logic          tag_we_d;
  logic          i_stall;
  logic          d_stall;
  logic          busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_we_i, fill_we_d, fill_word, fill_data,
           fill_block_addr, tag_we_i, tag_we_d, i_stall, d_stall, busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, fill_we_i, fill_we_d, fill_word, fill_data,
           fill_block_addr, tag_we_i, tag_we_d, i_stall, d_stall, busy
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// cache_fill_ctrl : arbitrates I/D cache misses and streams one block per fill
// Rev 1.0
// ============================================================================
module cache_fill_ctrl #(
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  cache_fill_ctrl_if.master bus
);
  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int DW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WW-1:0] C_LAST_WORD  = WW'(BLOCK_WORDS - 1);
  localparam logic [DW-1:0] C_LAST_DRAIN = DW'(MEM_LAT - 1);
  localparam logic [15:0]   C_BASE_MASK  = ~16'(2 * BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_DRAIN   = 3'd0,
    S_IDLE    = 3'd1,
    S_ISSUE   = 3'd2,
    S_COLLECT = 3'd3,
    S_TAG     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] iss_cnt_q, iss_cnt_d;
  logic [WW-1:0] rcv_cnt_q, rcv_cnt_d;
  logic [DW-1:0] drn_cnt_q, drn_cnt_d;
  logic [15:0]   base_q, base_d;
  logic          srv_i_q, srv_i_d;
  logic          srv_d_q, srv_d_d;
  logic          w_rcv;
  logic          w_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_DRAIN;
      iss_cnt_q <= '0;
      rcv_cnt_q <= '0;
      drn_cnt_q <= '0;
      base_q    <= '0;
      srv_i_q   <= 1'b0;
      srv_d_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      base_q    <= base_d;
      srv_i_q   <= srv_i_d;
      srv_d_q   <= srv_d_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    iss_cnt_d     = iss_cnt_q;
    rcv_cnt_d     = rcv_cnt_q;
    drn_cnt_d     = drn_cnt_q;
    base_d        = base_q;
    srv_i_d       = srv_i_q;
    srv_d_d       = srv_d_q;
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.fill_we_i = 1'b0;
    bus.fill_we_d = 1'b0;
    bus.tag_we_i  = 1'b0;
    bus.tag_we_d  = 1'b0;
    w_rcv         = ((state_q == S_ISSUE) || (state_q == S_COLLECT)) && bus.mem_data_valid;

    unique case (state_q)
      // Words still in flight from before reset are discarded here.
      S_DRAIN: begin
        drn_cnt_d = drn_cnt_q + 1'b1;
        if (drn_cnt_q == C_LAST_DRAIN) begin
          drn_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      S_IDLE: begin
        iss_cnt_d = '0;
        rcv_cnt_d = '0;
        if (bus.d_miss) begin
          base_d  = bus.d_miss_addr & C_BASE_MASK;
          srv_d_d = 1'b1;
          srv_i_d = 1'b0;
          state_d = S_ISSUE;
        end else if (bus.i_miss) begin
          base_d  = bus.i_miss_addr & C_BASE_MASK;
          srv_d_d = 1'b0;
          srv_i_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = base_q | 16'({iss_cnt_q, 1'b0});
        iss_cnt_d    = iss_cnt_q + 1'b1;
        if (iss_cnt_q == C_LAST_WORD) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        state_d = S_COLLECT;
      end
      S_TAG: begin
        bus.tag_we_i = srv_i_q;
        bus.tag_we_d = srv_d_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_DRAIN;
      end
    endcase

    // Receipt overlaps issue when latency is shorter than the block.
    if (w_rcv) begin
      bus.fill_we_i = srv_i_q;
      bus.fill_we_d = srv_d_q;
      rcv_cnt_d     = rcv_cnt_q + 1'b1;
      if (rcv_cnt_q == C_LAST_WORD) begin
        state_d = S_TAG;
      end
    end
  end

  assign w_busy              = (state_q != S_IDLE);
  assign bus.busy            = w_busy;
  assign bus.fill_word       = rcv_cnt_q;
  assign bus.fill_data       = bus.mem_data;
  assign bus.fill_block_addr = base_q;
  assign bus.i_stall         = bus.i_miss | (w_busy & srv_i_q);
  assign bus.d_stall         = bus.d_miss | (w_busy & srv_d_q);

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cache_fill_ctrl : scoreboard bench for cache_fill_ctrl (MEM_LAT 4 and 10)
// Rev 1.0
// ============================================================================
module tb_cache_fill_ctrl;
  localparam int BW    = 8;
  localparam int LAT_A = 4;
  localparam int LAT_B = 10;

  typedef struct packed {
    logic        is_d;
    logic [2:0]  word;
    logic [15:0] data;
  } fill_t;

  typedef struct packed {
    logic        is_d;
    logic [15:0] base;
  } tag_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic mem_clr = 1'b1;
  logic inj_a   = 1'b0;
  bit   mon_en  = 1'b0;
  int   checks  = 0;
  int   passes  = 0;

  logic [15:0] exp_iss_a[$];
  fill_t       exp_fill_a[$];
  tag_t        exp_tag_a[$];
  logic [15:0] ea;
  fill_t       ef;
  tag_t        et;

  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.BLOCK_WORDS(BW)) bus_a ();
  cache_fill_ctrl_if #(.BLOCK_WORDS(BW)) bus_b ();

  cache_fill_ctrl #(.MEM_LAT(LAT_A), .BLOCK_WORDS(BW)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  cache_fill_ctrl #(.MEM_LAT(LAT_B), .BLOCK_WORDS(BW)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Pipelined memory models: a read sampled at an edge returns LAT cycles later.
  logic [16:0] pipe_a [LAT_A];
  logic [16:0] pipe_b [LAT_B];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < LAT_A; i++) pipe_a[i] <= '0;
    end else begin
      pipe_a[0] <= {bus_a.mem_en, bus_a.mem_addr};
      for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int j = 0; j < LAT_B; j++) pipe_b[j] <= '0;
    end else begin
      pipe_b[0] <= {bus_b.mem_en, bus_b.mem_addr};
      for (int j = 1; j < LAT_B; j++) pipe_b[j] <= pipe_b[j-1];
    end
  end

  assign bus_a.mem_data_valid = pipe_a[LAT_A-1][16] | inj_a;
  assign bus_a.mem_data       = inj_a ? 16'hDEAD : mem_word(pipe_a[LAT_A-1][15:0]);
  assign bus_b.mem_data_valid = pipe_b[LAT_B-1][16];
  assign bus_b.mem_data       = mem_word(pipe_b[LAT_B-1][15:0]);

  // Scoreboard consumer for instance A.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_a.mem_en === 1'b1) begin
        checks++;
        if (exp_iss_a.size() == 0) begin
          $display("FAIL issue_unexpected: mem_addr=%h, no issue required", bus_a.mem_addr);
        end else begin
          ea = exp_iss_a.pop_front();
          if (bus_a.mem_addr !== ea) $display("FAIL issue_addr: got %h, required %h", bus_a.mem_addr, ea);
          else passes++;
        end
      end
      if (bus_a.fill_we_i === 1'b1 || bus_a.fill_we_d === 1'b1) begin
        checks++;
        if (exp_fill_a.size() == 0) begin
          $display("FAIL fill_unexpected: we_i=%b we_d=%b word=%0d", bus_a.fill_we_i, bus_a.fill_we_d, bus_a.fill_word);
        end else begin
          ef = exp_fill_a.pop_front();
          if (bus_a.fill_we_d !== ef.is_d || bus_a.fill_we_i !== !ef.is_d ||
              bus_a.fill_word !== ef.word || bus_a.fill_data !== ef.data)
            $display("FAIL fill_word: got we_i=%b we_d=%b word=%0d data=%h, required d=%b word=%0d data=%h",
                     bus_a.fill_we_i, bus_a.fill_we_d, bus_a.fill_word, bus_a.fill_data, ef.is_d, ef.word, ef.data);
          else passes++;
        end
      end
      if (bus_a.tag_we_i === 1'b1 || bus_a.tag_we_d === 1'b1) begin
        checks++;
        if (exp_tag_a.size() == 0) begin
          $display("FAIL tag_unexpected: tag_we_i=%b tag_we_d=%b", bus_a.tag_we_i, bus_a.tag_we_d);
        end else begin
          et = exp_tag_a.pop_front();
          if (bus_a.tag_we_d !== et.is_d || bus_a.tag_we_i !== !et.is_d || bus_a.fill_block_addr !== et.base)
            $display("FAIL tag_write: got we_i=%b we_d=%b block=%h, required d=%b block=%h",
                     bus_a.tag_we_i, bus_a.tag_we_d, bus_a.fill_block_addr, et.is_d, et.base);
          else passes++;
        end
      end
    end
  end

  task automatic push_block(input logic is_d, input logic [15:0] addr);
    logic [15:0] base;
    logic [15:0] a;
    fill_t       f;
    tag_t        t;
    base = addr & 16'hFFF0;
    for (int k = 0; k < BW; k++) begin
      a      = base + 16'(2 * k);
      f.is_d = is_d;
      f.word = 3'(k);
      f.data = mem_word(a);
      exp_iss_a.push_back(a);
      exp_fill_a.push_back(f);
    end
    t.is_d = is_d;
    t.base = base;
    exp_tag_a.push_back(t);
  endtask

  // Caller is 1 time unit into cycle 0; returns at the negedge of the tag cycle.
  task automatic wait_tag(output int tcyc, output int fiss, output int ffill,
                          output int ilow, output int dlow);
    tcyc = -1; fiss = -1; ffill = -1; ilow = 0; dlow = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus_a.mem_en === 1'b1 && fiss < 0) fiss = n;
      if ((bus_a.fill_we_i === 1'b1 || bus_a.fill_we_d === 1'b1) && ffill < 0) ffill = n;
      if (bus_a.i_stall !== 1'b1) ilow++;
      if (bus_a.d_stall !== 1'b1) dlow++;
      if (bus_a.tag_we_i === 1'b1 || bus_a.tag_we_d === 1'b1) begin
        tcyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int dr;
    int bad;
    dr = 0; bad = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.busy !== 1'b1) $display("FAIL rst_busy: got %b, required 1", bus_a.busy); else passes++;
    checks++; if (bus_a.i_stall !== 1'b0 || bus_a.d_stall !== 1'b0)
      $display("FAIL rst_stall: got i=%b d=%b, required 0 0", bus_a.i_stall, bus_a.d_stall); else passes++;
    checks++; if (bus_a.mem_en !== 1'b0 || bus_a.fill_block_addr !== 16'h0000)
      $display("FAIL rst_outputs: got mem_en=%b block=%h, required 0 0000", bus_a.mem_en, bus_a.fill_block_addr); else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    inj_a = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus_a.fill_we_i !== 1'b0 || bus_a.fill_we_d !== 1'b0 || bus_a.mem_en !== 1'b0) bad++;
      if (bus_a.busy === 1'b1) dr++;
      else break;
    end
    @(posedge clk);
    #1 inj_a = 1'b0;
    checks++; if (dr != LAT_A) $display("FAIL drain_len: got %0d cycles, required %0d", dr, LAT_A); else passes++;
    checks++; if (bad != 0) $display("FAIL drain_ignore: got %0d active cycles, required 0", bad); else passes++;
    mon_en = 1'b1;
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_iss_a.size() != 0 || exp_fill_a.size() != 0 || exp_tag_a.size() != 0)
      $display("FAIL %s_sb_left: got iss=%0d fill=%0d tag=%0d pending, required 0", name,
               exp_iss_a.size(), exp_fill_a.size(), exp_tag_a.size());
    else passes++;
  endtask

  task automatic test_single_d();
    int t, fi, ff, il, dl;
    @(posedge clk);
    #1 bus_a.d_miss = 1'b1; bus_a.d_miss_addr = 16'h1234;
    push_block(1'b1, 16'h1234);
    wait_tag(t, fi, ff, il, dl);
    checks++; if (t != 13) $display("FAIL d_tag_cycle: got %0d, required 13", t); else passes++;
    checks++; if (fi != 1) $display("FAIL d_first_issue: got %0d, required 1", fi); else passes++;
    checks++; if (ff != 5) $display("FAIL d_first_fill: got %0d, required 5", ff); else passes++;
    checks++; if (dl != 0 || il != 14) $display("FAIL d_stalls: got dlow=%0d ilow=%0d, required 0 14", dl, il); else passes++;
    @(posedge clk);
    #1 bus_a.d_miss = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.d_stall !== 1'b0 || bus_a.busy !== 1'b0)
      $display("FAIL d_release: got d_stall=%b busy=%b, required 0 0", bus_a.d_stall, bus_a.busy); else passes++;
    check_sb_empty("single_d");
  endtask

  task automatic test_both_miss();
    int t, fi, ff, il, dl;
    @(posedge clk);
    #1 bus_a.d_miss = 1'b1; bus_a.d_miss_addr = 16'h8000;
    bus_a.i_miss = 1'b1; bus_a.i_miss_addr = 16'h0040;
    push_block(1'b1, 16'h8000);
    push_block(1'b0, 16'h0040);
    wait_tag(t, fi, ff, il, dl);
    checks++; if (t != 13 || bus_a.tag_we_d !== 1'b1)
      $display("FAIL both_d_first: got tag cycle %0d tag_we_d=%b, required 13 1", t, bus_a.tag_we_d); else passes++;
    checks++; if (il != 0) $display("FAIL both_i_held: got %0d unstalled cycles, required 0", il); else passes++;
    @(posedge clk);
    #1 bus_a.d_miss = 1'b0;
    wait_tag(t, fi, ff, il, dl);
    checks++; if (fi != 1 || t != 13)
      $display("FAIL both_i_timing: got issue %0d tag %0d, required 1 13", fi, t); else passes++;
    checks++; if (il != 0) $display("FAIL both_i_stall: got %0d unstalled cycles, required 0", il); else passes++;
    @(posedge clk);
    #1 bus_a.i_miss = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.i_stall !== 1'b0) $display("FAIL both_i_release: got %b, required 0", bus_a.i_stall); else passes++;
    check_sb_empty("both");
  endtask

  task automatic test_i_drop();
    int t, fi, ff, il, dl;
    @(posedge clk);
    #1 bus_a.i_miss = 1'b1; bus_a.i_miss_addr = 16'h0306;
    push_block(1'b0, 16'h0306);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus_a.i_miss = 1'b0;
      end
    join_none
    wait_tag(t, fi, ff, il, dl);
    checks++; if (t != 13) $display("FAIL idrop_tag_cycle: got %0d, required 13", t); else passes++;
    checks++; if (il != 0 || dl != 14)
      $display("FAIL idrop_stalls: got ilow=%0d dlow=%0d, required 0 14", il, dl); else passes++;
    @(posedge clk);
    check_sb_empty("idrop");
  endtask

  task automatic test_wrap();
    int t, fi, ff, il, dl;
    @(posedge clk);
    #1 bus_a.d_miss = 1'b1; bus_a.d_miss_addr = 16'hFFFA;
    push_block(1'b1, 16'hFFFA);
    wait_tag(t, fi, ff, il, dl);
    checks++; if (t != 13 || bus_a.fill_block_addr !== 16'hFFF0)
      $display("FAIL wrap_block: got tag %0d block %h, required 13 fff0", t, bus_a.fill_block_addr); else passes++;
    @(posedge clk);
    #1 bus_a.d_miss = 1'b0;
    check_sb_empty("wrap");
  endtask

  task automatic test_reset_abort();
    int bad;
    int t, fi, ff, il, dl;
    bad = 0;
    mon_en = 1'b0;
    @(posedge clk);
    #1 bus_a.d_miss = 1'b1; bus_a.d_miss_addr = 16'h2000;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n >= 7 && (bus_a.fill_we_i !== 1'b0 || bus_a.fill_we_d !== 1'b0 ||
                     bus_a.tag_we_i !== 1'b0 || bus_a.tag_we_d !== 1'b0 || bus_a.mem_en !== 1'b0)) bad++;
      if (n == 9) begin
        checks++; if (bus_a.d_stall !== 1'b1) $display("FAIL abort_dstall: got %b, required 1", bus_a.d_stall); else passes++;
      end
      if (n == 11) begin
        checks++; if (bus_a.busy !== 1'b1) $display("FAIL abort_drain_end: got busy=%b, required 1", bus_a.busy); else passes++;
      end
      @(posedge clk);
      #1;
      if (n == 5) rst_n = 1'b0;
      if (n == 7) rst_n = 1'b1;
    end
    checks++; if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles, required 0", bad); else passes++;
    push_block(1'b1, 16'h2000);
    mon_en = 1'b1;
    wait_tag(t, fi, ff, il, dl);
    checks++; if (t != 13 || fi != 1 || ff != 5)
      $display("FAIL abort_refill: got tag %0d issue %0d fill %0d, required 13 1 5", t, fi, ff); else passes++;
    @(posedge clk);
    #1 bus_a.d_miss = 1'b0;
    check_sb_empty("abort");
  endtask

  task automatic test_long_latency();
    logic [15:0] iss_q[$];
    logic [15:0] dq[$];
    logic [15:0] a;
    logic [15:0] e;
    int tcyc, last_iss, ffill, widx;
    tcyc = -1; last_iss = -1; ffill = -1; widx = 0;
    @(posedge clk);
    #1 bus_b.d_miss = 1'b1; bus_b.d_miss_addr = 16'h4446;
    for (int k = 0; k < BW; k++) begin
      a = 16'h4440 + 16'(2 * k);
      iss_q.push_back(a);
      dq.push_back(mem_word(a));
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus_b.mem_en === 1'b1) begin
        last_iss = n;
        checks++;
        if (iss_q.size() == 0) $display("FAIL lat_issue_extra: mem_addr=%h", bus_b.mem_addr);
        else begin
          e = iss_q.pop_front();
          if (bus_b.mem_addr !== e) $display("FAIL lat_issue_addr: got %h, required %h", bus_b.mem_addr, e);
          else passes++;
        end
      end
      if (bus_b.fill_we_d === 1'b1 || bus_b.fill_we_i === 1'b1) begin
        if (ffill < 0) ffill = n;
        checks++;
        if (dq.size() == 0) $display("FAIL lat_fill_extra: word=%0d", bus_b.fill_word);
        else begin
          e = dq.pop_front();
          if (bus_b.fill_we_d !== 1'b1 || bus_b.fill_we_i !== 1'b0 ||
              bus_b.fill_word !== 3'(widx) || bus_b.fill_data !== e)
            $display("FAIL lat_fill: got we_d=%b word=%0d data=%h, required 1 %0d %h",
                     bus_b.fill_we_d, bus_b.fill_word, bus_b.fill_data, widx, e);
          else passes++;
          widx++;
        end
      end
      if (bus_b.tag_we_d === 1'b1 || bus_b.tag_we_i === 1'b1) begin
        tcyc = n;
        checks++;
        if (bus_b.tag_we_d !== 1'b1 || bus_b.fill_block_addr !== 16'h4440)
          $display("FAIL lat_tag: got tag_we_d=%b block=%h, required 1 4440", bus_b.tag_we_d, bus_b.fill_block_addr);
        else passes++;
        break;
      end
    end
    checks++; if (tcyc != 19) $display("FAIL lat_tag_cycle: got %0d, required 19", tcyc); else passes++;
    checks++; if (last_iss != 8 || ffill != 11)
      $display("FAIL lat_phases: got last issue %0d first fill %0d, required 8 11", last_iss, ffill); else passes++;
    checks++; if (iss_q.size() != 0 || dq.size() != 0)
      $display("FAIL lat_sb_left: got iss=%0d fill=%0d pending, required 0", iss_q.size(), dq.size()); else passes++;
    @(posedge clk);
    #1 bus_b.d_miss = 1'b0;
  endtask

  initial begin
    bus_a.i_miss = 1'b0; bus_a.i_miss_addr = '0;
    bus_a.d_miss = 1'b0; bus_a.d_miss_addr = '0;
    bus_b.i_miss = 1'b0; bus_b.i_miss_addr = '0;
    bus_b.d_miss = 1'b0; bus_b.d_miss_addr = '0;
    test_reset();
    test_single_d();
    test_both_miss();
    test_i_drop();
    test_wrap();
    test_reset_abort();
    test_long_latency();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
